// File: rtl/irq_bridge.sv
// -----------------------------------------------------------------------------
// irq_bridge
//   CPU-side bridge between the data-memory stage and the memory-mapped timer
//   slaves. It decodes CPU addresses into two 16-byte device windows and a
//   32-byte interrupt controller (ICU) window, and steers write strobes and
//   read data to match. The ICU prioritises the peripherals' IRQ lines and
//   drives a registered HWInt vector into CP0.
//
// Ports
//   clk       in   1        system clock, all state on posedge
//   reset     in   1        synchronous, active-low
//   PrAddr    in   32       CPU byte address
//   PrWE      in   1        CPU store strobe (one cycle per store)
//   PrWD      in   32       CPU store data
//   PrRD      out  32       read data to CPU (combinational from PrAddr)
//   DEV_Addr  out  4        PrAddr[3:0], shared by both devices
//   DEV_WD    out  32       PrWD, shared by both devices
//   DEV0_WE   out  1        store strobe for device 0 window
//   DEV1_WE   out  1        store strobe for device 1 window
//   DEV0_RD   in   32       device 0 read data
//   DEV1_RD   in   32       device 1 read data
//   IRQ_In    in   NUM_SRC  interrupt requests, bit 0 highest priority
//   HWInt     out  NUM_SRC  registered interrupt request to CP0
// -----------------------------------------------------------------------------
module irq_bridge #(
  parameter int          NUM_SRC   = 6,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter logic [31:0] ICU_BASE  = 32'h0000_7F20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        PrAddr,
  input  logic               PrWE,
  input  logic [31:0]        PrWD,
  output logic [31:0]        PrRD,
  output logic [3:0]         DEV_Addr,
  output logic [31:0]        DEV_WD,
  output logic               DEV0_WE,
  output logic               DEV1_WE,
  input  logic [31:0]        DEV0_RD,
  input  logic [31:0]        DEV1_RD,
  input  logic [NUM_SRC-1:0] IRQ_In,
  output logic [NUM_SRC-1:0] HWInt
);

  localparam int               PAD     = 32 - NUM_SRC;
  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1'b1);
  localparam logic [NUM_SRC-1:0] SRC_ALL = {NUM_SRC{1'b1}};
  localparam logic [NUM_SRC-1:0] SRC_ZERO = {NUM_SRC{1'b0}};

  // ICU register indices (PrAddr[4:2])
  localparam logic [2:0] R_MASK   = 3'd0;
  localparam logic [2:0] R_MODE   = 3'd1;
  localparam logic [2:0] R_PEND   = 3'd2;
  localparam logic [2:0] R_INSERV = 3'd3;
  localparam logic [2:0] R_ACK    = 3'd4;
  localparam logic [2:0] R_CAUSE  = 3'd5;

  // Index of the lowest set bit; 0 when the vector is empty (callers
  // qualify with a non-zero test).
  function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = i[2:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // One-hot of the lowest set bit (two's-complement isolate trick).
  function automatic logic [NUM_SRC-1:0] lowest_onehot(input logic [NUM_SRC-1:0] v);
    return v & (~v + SRC_ONE);
  endfunction

  // State
  logic [NUM_SRC-1:0] mask_q,   mask_d;
  logic [NUM_SRC-1:0] mode_q,   mode_d;
  logic [NUM_SRC-1:0] pend_q,   pend_d;
  logic [NUM_SRC-1:0] inserv_q, inserv_d;
  logic [NUM_SRC-1:0] irq_q,    irq_d;
  logic [NUM_SRC-1:0] hwint_q,  hwint_d;
  logic [31:0]        cause_q,  cause_d;

  // Decode
  logic       dev0_hit_s;
  logic       dev1_hit_s;
  logic       icu_hit_s;
  logic [2:0] reg_idx_s;
  logic       icu_we_s;

  assign dev0_hit_s = (PrAddr[31:4] == DEV0_BASE[31:4]);
  assign dev1_hit_s = (PrAddr[31:4] == DEV1_BASE[31:4]);
  assign icu_hit_s  = (PrAddr[31:5] == ICU_BASE[31:5]);
  assign reg_idx_s  = PrAddr[4:2];
  assign icu_we_s   = PrWE & icu_hit_s;

  assign DEV_Addr = PrAddr[3:0];
  assign DEV_WD   = PrWD;
  assign DEV0_WE  = PrWE & dev0_hit_s;
  assign DEV1_WE  = PrWE & dev1_hit_s;
  assign HWInt    = hwint_q;

  // Priority resolution
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] active_s;
  logic [NUM_SRC-1:0] win_oh_s;
  logic [2:0]         win_idx_s;

  // Only sources more urgent than the most urgent in-service one may interrupt.
  always_comb begin
    eligible_s = SRC_ALL;
    if (inserv_q != SRC_ZERO) begin
      eligible_s = lowest_onehot(inserv_q) - SRC_ONE;
    end else begin
      eligible_s = SRC_ALL;
    end
    active_s  = pend_q & mask_q & eligible_s;
    win_oh_s  = lowest_onehot(active_s);
    win_idx_s = lowest_idx(active_s);
  end

  // CPU read mux.
  always_comb begin
    PrRD = 32'h0000_0000;
    if (dev0_hit_s) begin
      PrRD = DEV0_RD;
    end else if (dev1_hit_s) begin
      PrRD = DEV1_RD;
    end else if (icu_hit_s) begin
      case (reg_idx_s)
        R_MASK:   PrRD = {{PAD{1'b0}}, mask_q};
        R_MODE:   PrRD = {{PAD{1'b0}}, mode_q};
        R_PEND:   PrRD = {{PAD{1'b0}}, pend_q};
        R_INSERV: PrRD = {{PAD{1'b0}}, inserv_q};
        R_CAUSE:  PrRD = cause_q;
        default:  PrRD = 32'h0000_0000;
      endcase
    end else begin
      PrRD = 32'h0000_0000;
    end
  end

  // ICU next-state logic.
  logic               wr_mask_s, wr_mode_s, wr_pend_s, wr_eoi_s, wr_ack_s;
  logic               ack_win_s;
  logic [NUM_SRC-1:0] pend_clr_s;
  logic [NUM_SRC-1:0] edge_set_s;
  logic [NUM_SRC-1:0] pend_edge_s;

  always_comb begin
    wr_mask_s = icu_we_s & (reg_idx_s == R_MASK);
    wr_mode_s = icu_we_s & (reg_idx_s == R_MODE);
    wr_pend_s = icu_we_s & (reg_idx_s == R_PEND);
    wr_eoi_s  = icu_we_s & (reg_idx_s == R_INSERV);
    wr_ack_s  = icu_we_s & (reg_idx_s == R_ACK);
    ack_win_s = wr_ack_s & (active_s != SRC_ZERO);

    if (wr_mask_s) begin
      mask_d = PrWD[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end

    if (wr_mode_s) begin
      mode_d = PrWD[NUM_SRC-1:0];
    end else begin
      mode_d = mode_q;
    end

    // Edge bits: a new rising edge beats any same-cycle clear. Level bits
    // simply follow the input. The old MODE is used, so a MODE write takes
    // effect on PEND from the following cycle.
    pend_clr_s  = (wr_pend_s ? PrWD[NUM_SRC-1:0] : SRC_ZERO)
                | (ack_win_s ? win_oh_s : SRC_ZERO);
    edge_set_s  = IRQ_In & ~irq_q;
    pend_edge_s = edge_set_s | (pend_q & ~pend_clr_s);
    pend_d      = (mode_q & pend_edge_s) | (~mode_q & IRQ_In);

    // EOI retires the most urgent in-service source (x & (x-1)).
    if (ack_win_s) begin
      inserv_d = inserv_q | win_oh_s;
    end else if (wr_eoi_s) begin
      inserv_d = inserv_q & (inserv_q - SRC_ONE);
    end else begin
      inserv_d = inserv_q;
    end

    if (wr_ack_s) begin
      if (ack_win_s) begin
        cause_d = {1'b1, 28'h000_0000, win_idx_s};
      end else begin
        cause_d = 32'h0000_0000;
      end
    end else begin
      cause_d = cause_q;
    end

    irq_d   = IRQ_In;
    hwint_d = active_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q   <= SRC_ZERO;
      mode_q   <= SRC_ZERO;
      pend_q   <= SRC_ZERO;
      inserv_q <= SRC_ZERO;
      irq_q    <= SRC_ZERO;
      hwint_q  <= SRC_ZERO;
      cause_q  <= 32'h0000_0000;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      inserv_q <= inserv_d;
      irq_q    <= irq_d;
      hwint_q  <= hwint_d;
      cause_q  <= cause_d;
    end
  end

endmodule

// File: tb/tb_irq_bridge.sv
// -----------------------------------------------------------------------------
// tb_irq_bridge
//   Directed self-checking bench for irq_bridge. Inputs change 1 ns after a
//   rising edge; outputs are sampled at that point (registered values) or after
//   a further 1 ns settle (combinational decode).
// -----------------------------------------------------------------------------
module tb_irq_bridge;

  localparam int NUM_SRC = 6;

  localparam logic [31:0] A_MASK   = 32'h0000_7F20;
  localparam logic [31:0] A_MODE   = 32'h0000_7F24;
  localparam logic [31:0] A_PEND   = 32'h0000_7F28;
  localparam logic [31:0] A_INSERV = 32'h0000_7F2C;
  localparam logic [31:0] A_ACK    = 32'h0000_7F30;
  localparam logic [31:0] A_CAUSE  = 32'h0000_7F34;
  localparam logic [31:0] A_IDLE   = 32'h0000_8000;
  localparam logic [31:0] D0_VAL   = 32'hD0D0_0A0A;
  localparam logic [31:0] D1_VAL   = 32'hD1D1_1B1B;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        PrAddr;
  logic               PrWE;
  logic [31:0]        PrWD;
  logic [31:0]        PrRD;
  logic [3:0]         DEV_Addr;
  logic [31:0]        DEV_WD;
  logic               DEV0_WE;
  logic               DEV1_WE;
  logic [31:0]        DEV0_RD;
  logic [31:0]        DEV1_RD;
  logic [NUM_SRC-1:0] IRQ_In;
  logic [NUM_SRC-1:0] HWInt;

  int checks = 0;
  int errors = 0;

  irq_bridge #(.NUM_SRC(NUM_SRC)) dut (
    .clk      (clk),
    .reset    (reset),
    .PrAddr   (PrAddr),
    .PrWE     (PrWE),
    .PrWD     (PrWD),
    .PrRD     (PrRD),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV0_WE  (DEV0_WE),
    .DEV1_WE  (DEV1_WE),
    .DEV0_RD  (DEV0_RD),
    .DEV1_RD  (DEV1_RD),
    .IRQ_In   (IRQ_In),
    .HWInt    (HWInt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    PrAddr = a;
    PrWD   = d;
    PrWE   = 1'b1;
    tick();
    PrWE   = 1'b0;
    PrAddr = A_IDLE;
    PrWD   = 32'h0000_0000;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    PrAddr = a;
    #1;
    check_eq(tag, PrRD, exp);
    PrAddr = A_IDLE;
  endtask

  task automatic check_hw(input string tag, input logic [NUM_SRC-1:0] exp);
    check_eq(tag, {26'h0, HWInt}, {26'h0, exp});
  endtask

  initial begin
    reset   = 1'b0;
    PrAddr  = A_IDLE;
    PrWE    = 1'b0;
    PrWD    = 32'h0000_0000;
    DEV0_RD = D0_VAL;
    DEV1_RD = D1_VAL;
    IRQ_In  = 6'h00;
    repeat (3) tick();
    reset = 1'b1;

    // Reset state
    check_hw("rst_hwint", 6'h00);
    check_rd("rst_mask", A_MASK, 32'h0);
    check_rd("rst_mode", A_MODE, 32'h0);
    check_rd("rst_cause", A_CAUSE, 32'h0);
    tick();

    // Address decode and strobes
    PrAddr = 32'h0000_7F00; PrWD = 32'h0000_0001; PrWE = 1'b1;
    #1;
    check_eq("dec_dev0_we", {31'h0, DEV0_WE}, 32'h1);
    check_eq("dec_dev1_we", {31'h0, DEV1_WE}, 32'h0);
    check_eq("dec_addr0", {28'h0, DEV_Addr}, 32'h0);
    check_eq("dec_wd", DEV_WD, 32'h0000_0001);
    PrAddr = 32'h0000_7F1C;
    #1;
    check_eq("dec_dev1_we_hi", {31'h0, DEV1_WE}, 32'h1);
    check_eq("dec_dev0_we_lo", {31'h0, DEV0_WE}, 32'h0);
    check_eq("dec_addr_c", {28'h0, DEV_Addr}, 32'hC);
    PrAddr = A_MASK; PrWD = 32'h0;
    #1;
    check_eq("dec_icu_no_we0", {31'h0, DEV0_WE}, 32'h0);
    check_eq("dec_icu_no_we1", {31'h0, DEV1_WE}, 32'h0);
    PrAddr = A_IDLE;
    #1;
    check_eq("dec_unmap_we", {30'h0, DEV0_WE, DEV1_WE}, 32'h0);
    PrWE = 1'b0;
    tick();
    check_rd("rd_dev0", 32'h0000_7F04, D0_VAL);
    check_rd("rd_dev1_14", 32'h0000_7F14, D1_VAL);
    check_rd("rd_dev1_18", 32'h0000_7F18, D1_VAL);
    check_rd("rd_icu_rsv18", 32'h0000_7F38, 32'h0);
    check_rd("rd_unmapped", 32'h0000_8000, 32'h0);
    tick();
    check_rd("rd_icu_ack", A_ACK, 32'h0);

    // Level source 1
    store(A_MASK, 32'h0000_0003);
    check_rd("lvl_mask", A_MASK, 32'h3);
    IRQ_In = 6'h02;
    tick();
    check_rd("lvl_pend", A_PEND, 32'h2);
    check_hw("lvl_hw_lat0", 6'h00);
    tick();
    check_hw("lvl_hw_on", 6'h02);
    IRQ_In = 6'h00;
    tick();
    check_rd("lvl_pend_drop", A_PEND, 32'h0);
    check_hw("lvl_hw_hold", 6'h02);
    tick();
    check_hw("lvl_hw_off", 6'h00);

    // Edge source 0 and ACK
    store(A_MASK, 32'h0000_0001);
    store(A_MODE, 32'h0000_0001);
    IRQ_In = 6'h01;
    tick();
    IRQ_In = 6'h00;
    tick();
    check_rd("edge_pend", A_PEND, 32'h1);
    check_hw("edge_hw", 6'h01);
    tick();
    check_rd("edge_pend_keep", A_PEND, 32'h1);
    store(A_ACK, 32'h0);
    check_rd("ack_cause", A_CAUSE, 32'h8000_0000);
    check_rd("ack_inserv", A_INSERV, 32'h1);
    check_rd("ack_pend", A_PEND, 32'h0);
    tick();
    check_hw("ack_hw", 6'h00);
    store(A_INSERV, 32'h0);
    check_rd("eoi0_inserv", A_INSERV, 32'h0);
    store(A_ACK, 32'h0);
    check_rd("ack_none_cause", A_CAUSE, 32'h0);
    check_rd("ack_none_inserv", A_INSERV, 32'h0);

    // Nesting
    store(A_MODE, 32'h0);
    store(A_MASK, 32'h0000_0004);
    IRQ_In = 6'h04;
    tick();
    store(A_ACK, 32'h0);
    check_rd("nest_inserv4", A_INSERV, 32'h4);
    check_rd("nest_cause2", A_CAUSE, 32'h8000_0002);
    IRQ_In = 6'h0A;
    store(A_MASK, 32'h0000_000F);
    tick();
    check_rd("nest_pend", A_PEND, 32'hA);
    check_hw("nest_hw02", 6'h02);
    store(A_ACK, 32'h0);
    check_rd("nest_inserv6", A_INSERV, 32'h6);
    check_rd("nest_cause1", A_CAUSE, 32'h8000_0001);
    IRQ_In = 6'h08;
    store(A_INSERV, 32'h0);
    check_rd("nest_eoi1", A_INSERV, 32'h4);
    store(A_INSERV, 32'h0);
    check_rd("nest_eoi2", A_INSERV, 32'h0);
    check_hw("nest_hw_lat", 6'h00);
    tick();
    check_hw("nest_hw08", 6'h08);

    // W1C versus a simultaneous new edge
    IRQ_In = 6'h00;
    store(A_MODE, 32'h0000_0001);
    store(A_MASK, 32'h0000_0001);
    IRQ_In = 6'h01;
    tick();
    IRQ_In = 6'h00;
    tick();
    check_rd("w1c_pre", A_PEND, 32'h1);
    store(A_PEND, 32'h0000_0001);
    check_rd("w1c_clear", A_PEND, 32'h0);
    IRQ_In = 6'h01;
    store(A_PEND, 32'h0000_0001);
    check_rd("w1c_race", A_PEND, 32'h1);

    // Reset in the middle of service, source held high
    tick();
    store(A_ACK, 32'h0);
    check_rd("mid_inserv", A_INSERV, 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_rd("srst_mask", A_MASK, 32'h0);
    check_rd("srst_mode", A_MODE, 32'h0);
    check_rd("srst_pend", A_PEND, 32'h0);
    check_rd("srst_inserv", A_INSERV, 32'h0);
    check_rd("srst_cause", A_CAUSE, 32'h0);
    check_hw("srst_hw", 6'h00);
    store(A_MODE, 32'h0000_0001);
    check_rd("post_rst_pend", A_PEND, 32'h1);
    tick();
    check_rd("post_rst_hold", A_PEND, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
